// File: rtl/mem_bus_subsystem.sv
// CPU memory subsystem: single-beat master FSM, address-decoded bus,
// byte-enabled on-chip RAM and a read-only UFM flash port.
module mem_bus_subsystem #(
  parameter logic [31:0] UFM_BASE  = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE  = 32'h1000_0000,
  parameter int          RAM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_dataena,
  input  logic [7:0]  cpu_burstcount,
  output logic [31:0] cpu_rdata,
  output logic        cpu_valid,
  output logic [16:0] ufm_addr,
  output logic        ufm_read,
  output logic [3:0]  ufm_burstcount,
  input  logic [31:0] ufm_rdata,
  input  logic        ufm_waitrequest,
  input  logic        ufm_valid
);

  localparam int AW = $clog2(RAM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;

  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_ena;
  logic        lat_wr;

  logic        ufm_chsel, ram_chsel, ufm_sel, none_sel;
  logic        ram_read, ram_write, ram_valid, none_valid;
  logic [31:0] ram_rdata, bus_rdata;
  logic        bus_valid, bus_wait;
  logic [AW-1:0] ram_idx;

  logic [31:0] mem [RAM_WORDS];

  assign ufm_chsel = (lat_addr[31:19] == UFM_BASE[31:19]);
  assign ram_chsel = (lat_addr[31:12] == RAM_BASE[31:12]);
  // UFM is read-only: writes there fall through to the null slave
  assign ufm_sel   = ufm_chsel && !ram_chsel && !lat_wr;
  assign none_sel  = !ufm_sel && !ram_chsel;
  assign ram_idx   = lat_addr[AW+1:2];

  assign ufm_read       = (state == REQ) && ufm_sel;
  assign ufm_addr       = lat_addr[18:2];
  assign ufm_burstcount = 4'd1;
  assign ram_read       = (state == REQ) && ram_chsel && !lat_wr;
  assign ram_write      = (state == REQ) && ram_chsel && lat_wr;
  assign cpu_valid      = (state == RESP);

  always_comb begin
    bus_wait  = 1'b0;
    bus_valid = none_valid;
    bus_rdata = '0;
    unique case (1'b1)
      ram_chsel: begin
        bus_valid = ram_valid;
        bus_rdata = ram_rdata;
      end
      ufm_sel: begin
        bus_wait  = ufm_waitrequest;
        bus_valid = ufm_valid;
        bus_rdata = ufm_rdata;
      end
      none_sel: begin
        bus_valid = none_valid;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (cpu_read || cpu_write) state_n = REQ;
      REQ:  if (!bus_wait) state_n = WAIT;
      WAIT: if (bus_valid) state_n = RESP;
      RESP: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_ena    <= '0;
      lat_wr     <= 1'b0;
      cpu_rdata  <= '0;
      ram_valid  <= 1'b0;
      none_valid <= 1'b0;
    end else begin
      state      <= state_n;
      ram_valid  <= ram_read || ram_write;
      none_valid <= (state == REQ) && none_sel;
      if (state == IDLE && (cpu_read || cpu_write)) begin
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
        lat_ena   <= cpu_dataena;
        lat_wr    <= !cpu_read;
      end
      if (state == WAIT && bus_valid)
        cpu_rdata <= lat_wr ? 32'h0 : bus_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_write) begin
      for (int i = 0; i < 4; i++)
        if (lat_ena[i]) mem[ram_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
    end
    if (ram_read) ram_rdata <= mem[ram_idx];
  end

  logic unused_bits;
  assign unused_bits = ^{cpu_burstcount, lat_addr[1:0]};

endmodule

// File: tb/tb_mem_bus_subsystem.sv
// Bench for mem_bus_subsystem: word-level memory model, UFM slave model
// with wait/latency, and a per-cycle completion scoreboard.
module tb_mem_bus_subsystem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [3:0]  cpu_dataena = '0;
  logic [7:0]  cpu_burstcount = 8'd1;
  logic [31:0] cpu_rdata;
  logic        cpu_valid;
  logic [16:0] ufm_addr;
  logic        ufm_read;
  logic [3:0]  ufm_burstcount;
  logic [31:0] ufm_rdata;
  logic        ufm_waitrequest;
  logic        ufm_valid;

  int checks = 0;
  int failures = 0;

  mem_bus_subsystem dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_dataena(cpu_dataena), .cpu_burstcount(cpu_burstcount),
    .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid),
    .ufm_addr(ufm_addr), .ufm_read(ufm_read),
    .ufm_burstcount(ufm_burstcount), .ufm_rdata(ufm_rdata),
    .ufm_waitrequest(ufm_waitrequest), .ufm_valid(ufm_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ufm_word(input logic [16:0] idx);
    return 32'h5A00_0000 + {15'd0, idx} * 32'h0001_0101;
  endfunction

  // UFM slave: waitrequest for 2 cycles, data valid 3 edges after accept
  int          wcnt = 0;
  int          vcnt = 0;
  logic [16:0] paddr = '0;
  assign ufm_waitrequest = ufm_read && (wcnt < 2);
  assign ufm_valid = (vcnt == 1);
  assign ufm_rdata = ufm_valid ? ufm_word(paddr) : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (!ufm_read) wcnt <= 0;
    else if (ufm_waitrequest) wcnt <= wcnt + 1;
    else begin
      wcnt  <= 0;
      vcnt  <= 3;
      paddr <= ufm_addr;
    end
    if (!(ufm_read && !ufm_waitrequest) && vcnt != 0) vcnt <= vcnt - 1;
  end

  // Reference model
  logic [31:0] mram [1024];
  logic [31:0] exp_q [$];
  logic        ufm_ok = 1'b0;
  logic [16:0] exp_ufm_addr = '0;
  logic        prev_valid = 1'b0;
  logic        run = 1'b0;

  task automatic model_issue(input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] en, input bit rd);
    logic [31:0] e;
    logic [31:0] w;
    e = 32'h0;
    ufm_ok = rd && (a[31:19] == 13'd0);
    exp_ufm_addr = a[18:2];
    if (a[31:12] == 20'h10000) begin
      if (rd) e = mram[a[11:2]];
      else begin
        w = mram[a[11:2]];
        for (int i = 0; i < 4; i++)
          if (en[i]) w[8*i +: 8] = wd[8*i +: 8];
        mram[a[11:2]] = w;
      end
    end else if (a[31:19] == 13'd0 && rd) begin
      e = ufm_word(a[18:2]);
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (run && !rst) begin
      if (cpu_valid) begin
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid got rdata=%h, required no strobe", cpu_rdata);
        end else begin
          e = exp_q.pop_front();
          if (cpu_rdata !== e || prev_valid) begin
            failures++;
            $display("FAIL rdata got=%h required=%h (valid twice=%0b, required 0)",
                     cpu_rdata, e, prev_valid);
          end
        end
      end
      if (ufm_read) begin
        checks++;
        if (!ufm_ok || ufm_addr !== exp_ufm_addr || ufm_burstcount !== 4'd1) begin
          failures++;
          $display("FAIL ufm_strobe allowed=%0b addr got=%h required=%h burst=%0d",
                   ufm_ok, ufm_addr, exp_ufm_addr, ufm_burstcount);
        end
      end
    end
    prev_valid = cpu_valid;
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = cpu_valid;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s timeout got no cpu_valid, required one", name);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] en, input bit rd,
                        output logic [31:0] got);
    @(negedge clk);
    cpu_addr = a;
    cpu_wdata = wd;
    cpu_dataena = en;
    cpu_read = rd;
    cpu_write = !rd;
    model_issue(a, wd, en, rd);
    wait_valid("access");
    got = cpu_rdata;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  logic [31:0] got;

  initial begin
    for (int i = 0; i < 1024; i++) mram[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'd0, cpu_valid}, 32'd0);
    check("reset_rdata", cpu_rdata, 32'd0);
    check("reset_ufm_read", {31'd0, ufm_read}, 32'd0);
    rst = 1'b0;
    run = 1'b1;

    // word write then readback
    access(32'h1000_0000, 32'hDEAD_BEEF, 4'b1111, 1'b0, got);
    access(32'h1000_0000, 32'h0, 4'b1111, 1'b1, got);
    check("word_read", got, 32'hDEAD_BEEF);

    // halfword write over AAAA_AAAA
    access(32'h1000_0004, 32'hAAAA_AAAA, 4'b1111, 1'b0, got);
    access(32'h1000_0006, 32'h1234_0000, 4'b1100, 1'b0, got);
    access(32'h1000_0004, 32'h0, 4'b1111, 1'b1, got);
    check("half_read", got, 32'h1234_AAAA);

    // byte lanes, one per offset
    access(32'h1000_0020, 32'h0, 4'b1111, 1'b0, got);
    access(32'h1000_0020, 32'h0000_0011, 4'b0001, 1'b0, got);
    access(32'h1000_0021, 32'h0000_2200, 4'b0010, 1'b0, got);
    access(32'h1000_0022, 32'h0033_0000, 4'b0100, 1'b0, got);
    access(32'h1000_0023, 32'h4400_0000, 4'b1000, 1'b0, got);
    access(32'h1000_0020, 32'h0, 4'b1111, 1'b1, got);
    check("byte_read", got, 32'h4433_2211);
    access(32'h1000_0024, 32'hFFFF_FFFF, 4'b1111, 1'b0, got);
    access(32'h1000_0026, 32'h0055_0000, 4'b0100, 1'b0, got);
    access(32'h1000_0024, 32'h0, 4'b1111, 1'b1, got);
    check("byte_lane2", got, 32'hFF55_FFFF);

    // UFM -> RAM copy
    for (int i = 0; i < 20; i++) begin
      logic [31:0] d;
      access(32'h0000_0000 + 32'(4 * i), 32'h0, 4'b1111, 1'b1, d);
      if (i == 3) check("ufm_word3", d, 32'h5A03_0303);
      access(32'h1000_0000 + 32'(4 * i), d, 4'b1111, 1'b0, got);
    end

    // back-to-back halfword reads with cpu_read held
    @(negedge clk);
    cpu_addr = 32'h1000_0000;
    cpu_dataena = 4'b0011;
    cpu_read = 1'b1;
    model_issue(cpu_addr, 32'h0, cpu_dataena, 1'b1);
    for (int k = 0; k < 20; k++) begin
      wait_valid("b2b");
      if (k == 19) begin
        check("b2b_last", cpu_rdata, 32'h5A13_1313);
        cpu_read = 1'b0;
      end else begin
        cpu_addr = 32'h1000_0000 + 32'(4 * (k + 1)) + ((k + 1) % 2 == 1 ? 32'd2 : 32'd0);
        cpu_dataena = ((k + 1) % 2 == 1) ? 4'b1100 : 4'b0011;
        model_issue(cpu_addr, 32'h0, cpu_dataena, 1'b1);
      end
    end

    // UFM write dropped, unmapped read returns 0
    access(32'h0000_0010, 32'hCAFE_F00D, 4'b1111, 1'b0, got);
    access(32'h2000_0000, 32'h0, 4'b1111, 1'b1, got);
    check("unmapped_read", got, 32'h0);
    access(32'h0000_0010, 32'h0, 4'b1111, 1'b1, got);
    check("ufm_after_write", got, 32'h5A04_0404);

    // reset while waiting on a UFM read
    @(negedge clk);
    cpu_addr = 32'h0000_0040;
    cpu_dataena = 4'b1111;
    cpu_read = 1'b1;
    ufm_ok = 1'b1;
    exp_ufm_addr = 17'd16;
    begin
      bit seen_strobe, in_wait;
      seen_strobe = 1'b0;
      in_wait = 1'b0;
      for (int n = 0; n < 30 && !in_wait; n++) begin
        @(negedge clk);
        if (ufm_read) seen_strobe = 1'b1;
        else if (seen_strobe) in_wait = 1'b1;
      end
      check("reach_wait", {31'd0, in_wait}, 32'd1);
    end
    rst = 1'b1;
    cpu_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ufm_ok = 1'b0;
    begin
      int nv;
      nv = 0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (cpu_valid || ufm_read) nv++;
      end
      check("abandoned_strobes", 32'(nv), 32'd0);
    end
    access(32'h1000_0000, 32'h0, 4'b1111, 1'b1, got);
    check("after_reset_read", got, 32'h5A00_0000);

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
